warp_fetch_scheduler: RTL and testbench
=======================================

# warp_fetch_scheduler

Per-warp fetch sequencer in front of the instruction cache. Holds PC and active mask for up to NumWarps warps and picks one eligible warp per cycle by round-robin. Drives a fetch request (pc, act_mask, warp id) into the instruction cache's fetch port. Allows at most one in-flight fetch per warp, and re-arms a warp only when the downstream pipeline reports its next PC or its termination.

## Interface
- PcWidth, 8, program counter width in bits
- NumWarps, 8, number of warp slots; must be ≥ 1
- WarpWidth, 4, threads per warp (active-mask width)
- WidWidth, NumWarps > 1 ? $clog2(NumWarps) : 1, warp id width (derived, not overridable)
- PerfCntWidth, 16, width of the performance counter (used only with BGPU_WFS_PERF_EN)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset, synchronous, active-low
- alloc_valid_i  in  1  request to start a new warp
- alloc_ready_o  out  1  a free warp slot exists
- alloc_pc_i  in  PcWidth  start PC
- alloc_act_mask_i  in  WarpWidth  initial active mask
- alloc_warp_id_o  out  WidWidth  slot that will be used by the allocation (valid with alloc_ready_o)
- fe_valid_o  out  1  fetch request valid
- ic_ready_i  in  1  instruction cache accepts fetch
- fe_pc_o  out  PcWidth  fetch PC
- fe_act_mask_o  out  WarpWidth  fetch active mask
- fe_warp_id_o  out  WidWidth  fetch warp id
- upd_valid_i  in  1  post-decode update for one warp (single-cycle pulse, no ready)
- upd_warp_id_i  in  WidWidth  warp being updated
- upd_next_pc_i  in  PcWidth  next PC for that warp
- upd_act_mask_i  in  WarpWidth  new active mask
- upd_done_i  in  1  warp has terminated; free the slot
- busy_o  out  1  at least one slot is not FREE
- fetch_cnt_o  out  PerfCntWidth  accepted fetches (only with BGPU_WFS_PERF_EN)

## Operation
- Per-slot state: FREE, READY, WAITING; per-slot PC and act_mask registers.
- Allocation:
  - alloc_warp_id_o = lowest-index FREE slot; alloc_ready_o = any slot FREE.
  - On alloc_valid_i && alloc_ready_o the slot loads PC/mask and goes FREE→READY.
- Fetch arbitration:
  - Round-robin over READY slots, starting at rr_ptr.
  - fe_valid_o = any READY slot; fe_* come from the selected slot.
  - On fe_valid_o && ic_ready_i: selected slot READY→WAITING; rr_ptr ← selected+1, wrapping NumWarps-1→0.
  - rr_ptr does not change without a handshake.
- Update (upd_valid_i):
  - Target slot in WAITING and upd_done_i=0: load upd_next_pc_i and upd_act_mask_i, go WAITING→READY.
  - Target slot in WAITING and upd_done_i=1: go WAITING→FREE; PC and mask are don't-care.
  - Target slot not in WAITING: the update is ignored and a simulation assertion fires.
  - upd_warp_id_i ≥ NumWarps: the update is ignored and a simulation assertion fires.
- upd_act_mask_i == 0 with upd_done_i=0 is treated as done (slot→FREE).
- PC arithmetic is the caller's; stored PC wraps naturally at 2^PcWidth.
- busy_o = OR of (state != FREE).

## Timing
- Reset (rst_ni=0 at a rising edge):
  - all slots FREE, rr_ptr=0, fetch_cnt_o=0;
  - outputs: fe_valid_o=0, alloc_ready_o=1, alloc_warp_id_o=0, busy_o=0; fe_* data = 0.
- Reset mid-operation discards all warps. Updates arriving after reset target FREE slots and are ignored.
- fe_* and alloc_* outputs are combinational from registered state only; there is no combinational path from any input to any output.
- Valid/data stability: while fe_valid_o && !ic_ready_i, fe_* stay stable. The selected slot stays READY because alloc only targets FREE slots and upd only targets WAITING slots.
- Latencies:
  - Allocation → first fetch visible: 1 cycle (alloc at edge N, fe_valid_o high after edge N).
  - Update → re-fetch of the same warp: earliest the cycle after the update edge.
- Simultaneous events in one cycle:
  - Alloc, fetch handshake and update all apply in the same edge to distinct slots by construction.
  - A slot freed by upd_done_i is not offered to alloc until the next cycle.
  - An alloc and a fetch of the same slot cannot coincide.
- All slots WAITING/FREE → fe_valid_o=0. All slots non-FREE → alloc_ready_o=0; alloc_warp_id_o then holds 0 and is don't-care.

## Configuration
- Macro BGPU_WFS_PERF_EN.
- Defined:
  - fetch_cnt_o counts accepted fetch handshakes and saturates at 2^PerfCntWidth-1.
  - It is reset to 0.
- Undefined:
  - fetch_cnt_o is tied to 0 and no counter register exists.
  - All other behaviour is identical.

## Test plan
- Reset then alloc pc=0x10, mask=4'b1111 → alloc_warp_id_o=0; next cycle fe_valid_o=1, fe_pc_o=0x10, fe_warp_id_o=0, fe_act_mask_o=4'b1111.
- Alloc warps 0,1,2 (pc 0x00/0x20/0x40), ic_ready_i=1, each warp updated with pc+1 two cycles after its fetch → fetch order 0,1,2,0,1,2 with PCs 0x00,0x20,0x40,0x01,0x21,0x41.
- Hold ic_ready_i=0 for 5 cycles with warp 3 selected → fe_* unchanged for all 5 cycles, rr_ptr unchanged; release → warp 3 accepted, next selection starts at 4.
- Fill all 8 slots → alloc_ready_o=0; upd_done_i=1 on WAITING warp 5 → next cycle alloc_ready_o=1, alloc_warp_id_o=5; busy_o=0 only after all 8 are done.
- Update to a READY warp, and an update with upd_act_mask_i=0 → first is ignored and asserts; second frees the slot. No fetch is issued for either.
- With BGPU_WFS_PERF_EN and PerfCntWidth=4: 20 accepted fetches → fetch_cnt_o=15. Without the macro → fetch_cnt_o=0 throughout.

Source files
------------

// File: rtl/warp_fetch_scheduler.sv
// Per-warp fetch sequencer: round-robin picks one READY warp per cycle for the I-cache.
// Optional accepted-fetch counter enabled by BGPU_WFS_PERF_EN.
module warp_fetch_scheduler #(
  parameter int unsigned PcWidth      = 8,
  parameter int unsigned NumWarps     = 8,
  parameter int unsigned WarpWidth    = 4,
  parameter int unsigned PerfCntWidth = 16,
  localparam int unsigned WidWidth    = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    alloc_valid_i,
  output logic                    alloc_ready_o,
  input  logic [PcWidth-1:0]      alloc_pc_i,
  input  logic [WarpWidth-1:0]    alloc_act_mask_i,
  output logic [WidWidth-1:0]     alloc_warp_id_o,
  output logic                    fe_valid_o,
  input  logic                    ic_ready_i,
  output logic [PcWidth-1:0]      fe_pc_o,
  output logic [WarpWidth-1:0]    fe_act_mask_o,
  output logic [WidWidth-1:0]     fe_warp_id_o,
  input  logic                    upd_valid_i,
  input  logic [WidWidth-1:0]     upd_warp_id_i,
  input  logic [PcWidth-1:0]      upd_next_pc_i,
  input  logic [WarpWidth-1:0]    upd_act_mask_i,
  input  logic                    upd_done_i,
  output logic                    busy_o,
  output logic [PerfCntWidth-1:0] fetch_cnt_o
);

  localparam logic [1:0] StFree  = 2'd0;
  localparam logic [1:0] StReady = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]           state_q [NumWarps];
  logic [1:0]           state_d [NumWarps];
  logic [PcWidth-1:0]   pc_q    [NumWarps];
  logic [PcWidth-1:0]   pc_d    [NumWarps];
  logic [WarpWidth-1:0] mask_q  [NumWarps];
  logic [WarpWidth-1:0] mask_d  [NumWarps];
  logic [WidWidth-1:0]  rr_q, rr_d;

  logic                 sel_found;
  logic [WidWidth-1:0]  sel_id;
  logic                 fire;
  logic                 upd_in_range;

  // Allocation target and round-robin selection, from registered state only
  always_comb begin
    alloc_ready_o   = 1'b0;
    alloc_warp_id_o = '0;
    busy_o          = 1'b0;
    sel_found       = 1'b0;
    sel_id          = '0;
    for (int i = NumWarps - 1; i >= 0; i--) begin
      if (state_q[WidWidth'(i)] == StFree) begin
        alloc_ready_o   = 1'b1;
        alloc_warp_id_o = WidWidth'(i);
      end else begin
        busy_o = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NumWarps; k++) begin
      if (!sel_found &&
          state_q[WidWidth'((32'(rr_q) + k) % NumWarps)] == StReady) begin
        sel_found = 1'b1;
        sel_id    = WidWidth'((32'(rr_q) + k) % NumWarps);
      end
    end
  end

  assign fire          = sel_found && ic_ready_i;
  assign fe_valid_o    = sel_found;
  assign fe_pc_o       = sel_found ? pc_q[sel_id]   : '0;
  assign fe_act_mask_o = sel_found ? mask_q[sel_id] : '0;
  assign fe_warp_id_o  = sel_found ? sel_id         : '0;

  // Update, allocation and fetch always touch distinct slots in one cycle
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mask_d       = mask_q;
    rr_d         = rr_q;
    upd_in_range = 32'(upd_warp_id_i) < NumWarps;

    if (upd_valid_i && upd_in_range && state_q[upd_warp_id_i] == StWait) begin
      if (upd_done_i || upd_act_mask_i == '0) begin
        state_d[upd_warp_id_i] = StFree;
      end else begin
        state_d[upd_warp_id_i] = StReady;
        pc_d[upd_warp_id_i]    = upd_next_pc_i;
        mask_d[upd_warp_id_i]  = upd_act_mask_i;
      end
    end

    if (alloc_valid_i && alloc_ready_o) begin
      state_d[alloc_warp_id_o] = StReady;
      pc_d[alloc_warp_id_o]    = alloc_pc_i;
      mask_d[alloc_warp_id_o]  = alloc_act_mask_i;
    end

    if (fire) begin
      state_d[sel_id] = StWait;
      rr_d = (sel_id == WidWidth'(NumWarps - 1)) ? '0 : sel_id + WidWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q <= '0;
      for (int i = 0; i < NumWarps; i++) begin
        state_q[i] <= StFree;
        pc_q[i]    <= '0;
        mask_q[i]  <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
    end
  end

  // Illegal updates are dropped by the datapath; flag them in simulation
  always_ff @(posedge clk_i) begin
    if (rst_ni && upd_valid_i) begin
      assert (upd_in_range)
        else $error("update to out-of-range warp id ignored");
      assert (!upd_in_range || state_q[upd_warp_id_i] == StWait)
        else $error("update to non-WAITING warp ignored");
    end
  end

`ifdef BGPU_WFS_PERF_EN
  logic [PerfCntWidth-1:0] fetch_cnt_q, fetch_cnt_d;

  // Saturating count of accepted fetch handshakes
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (fire && fetch_cnt_q != '1) begin
      fetch_cnt_d = fetch_cnt_q + PerfCntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
`else
  assign fetch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Self-checking bench for warp_fetch_scheduler against a slot-level behavioural model.
module tb_warp_fetch_scheduler;

  localparam int NW = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_ELIG = 1;
  localparam int M_OUT  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_valid;
  logic [7:0] alloc_pc;
  logic [3:0] alloc_mask;
  logic       ic_ready;
  logic       upd_valid;
  logic [2:0] upd_id;
  logic [7:0] upd_pc;
  logic [3:0] upd_mask;
  logic       upd_done;

  logic          alloc_ready;
  logic [2:0]    alloc_id;
  logic          fe_valid;
  logic [7:0]    fe_pc;
  logic [3:0]    fe_mask;
  logic [2:0]    fe_wid;
  logic          busy;
  logic [CW-1:0] fetch_cnt;

  warp_fetch_scheduler #(
    .PcWidth(8), .NumWarps(NW), .WarpWidth(4), .PerfCntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
    .alloc_pc_i(alloc_pc), .alloc_act_mask_i(alloc_mask), .alloc_warp_id_o(alloc_id),
    .fe_valid_o(fe_valid), .ic_ready_i(ic_ready),
    .fe_pc_o(fe_pc), .fe_act_mask_o(fe_mask), .fe_warp_id_o(fe_wid),
    .upd_valid_i(upd_valid), .upd_warp_id_i(upd_id), .upd_next_pc_i(upd_pc),
    .upd_act_mask_i(upd_mask), .upd_done_i(upd_done),
    .busy_o(busy), .fetch_cnt_o(fetch_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: per-slot status, PC, mask; rotating priority start; fetch count
  int         m_st   [NW];
  logic [7:0] m_pc   [NW];
  logic [3:0] m_mask [NW];
  int         m_rr;
  int         m_cnt;

  logic e_fv, e_ar, e_busy;
  int   e_sel, e_aid;

  function automatic void m_outputs();
    e_fv = 1'b0; e_ar = 1'b0; e_busy = 1'b0; e_sel = 0; e_aid = 0;
    for (int i = 0; i < NW; i++) begin
      if (m_st[i] == M_IDLE && !e_ar) begin e_ar = 1'b1; e_aid = i; end
      if (m_st[i] != M_IDLE) e_busy = 1'b1;
    end
    for (int k = 0; k < NW; k++) begin
      if (!e_fv && m_st[(m_rr + k) % NW] == M_ELIG) begin
        e_fv = 1'b1;
        e_sel = (m_rr + k) % NW;
      end
    end
  endfunction

  function automatic int exp_cnt();
`ifdef BGPU_WFS_PERF_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic void m_edge();
    m_outputs();
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) begin m_st[i] = M_IDLE; m_pc[i] = '0; m_mask[i] = '0; end
      m_rr = 0; m_cnt = 0;
      return;
    end
    if (upd_valid && m_st[upd_id] == M_OUT) begin
      if (upd_done || upd_mask == 4'd0) m_st[upd_id] = M_IDLE;
      else begin m_st[upd_id] = M_ELIG; m_pc[upd_id] = upd_pc; m_mask[upd_id] = upd_mask; end
    end
    if (alloc_valid && e_ar) begin
      m_st[e_aid] = M_ELIG; m_pc[e_aid] = alloc_pc; m_mask[e_aid] = alloc_mask;
    end
    if (e_fv && ic_ready) begin
      m_st[e_sel] = M_OUT;
      m_rr = (e_sel + 1) % NW;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
  endfunction

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
    m_outputs();
  endtask

  task automatic clear_inputs();
    alloc_valid = 0; alloc_pc = '0; alloc_mask = '0; ic_ready = 0;
    upd_valid = 0; upd_id = '0; upd_pc = '0; upd_mask = '0; upd_done = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fe_valid !== 1'b0 || alloc_ready !== 1'b1 || alloc_id !== 3'd0 || busy !== 1'b0 ||
        fe_pc !== 8'h00 || fe_mask !== 4'h0 || fe_wid !== 3'd0 || fetch_cnt !== '0) begin
      errors++;
      $display("FAIL reset: got fv=%b ar=%b aid=%0d busy=%b pc=%h mask=%h wid=%0d cnt=%0d, want 0 1 0 0 00 0 0 0",
               fe_valid, alloc_ready, alloc_id, busy, fe_pc, fe_mask, fe_wid, fetch_cnt);
    end
  endtask

  task automatic test_first_fetch();
    do_reset();
    alloc_valid = 1; alloc_pc = 8'h10; alloc_mask = 4'hF;
    checks++;
    if (alloc_ready !== 1'b1 || alloc_id !== 3'd0) begin
      errors++;
      $display("FAIL first_alloc_id: got ar=%b id=%0d, want 1 0", alloc_ready, alloc_id);
    end
    tick();
    alloc_valid = 0;
    checks++;
    if (fe_valid !== 1'b1 || fe_pc !== 8'h10 || fe_wid !== 3'd0 || fe_mask !== 4'hF) begin
      errors++;
      $display("FAIL first_fetch: got v=%b pc=%h wid=%0d mask=%h, want 1 10 0 f",
               fe_valid, fe_pc, fe_wid, fe_mask);
    end
  endtask

  task automatic test_round_robin();
    int due [NW];
    int got_id [6];
    int got_pc [6];
    int exp_id [6] = '{0, 1, 2, 0, 1, 2};
    int exp_pc [6] = '{'h00, 'h20, 'h40, 'h01, 'h21, 'h41};
    int n = 0;
    do_reset();
    for (int w = 0; w < 3; w++) begin
      alloc_valid = 1; alloc_pc = 8'(w * 'h20); alloc_mask = 4'hF;
      tick();
    end
    alloc_valid = 0;
    ic_ready = 1;
    for (int w = 0; w < NW; w++) due[w] = -1;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      checks++;
      if (fe_valid !== e_fv || (e_fv && (fe_pc !== m_pc[e_sel] || fe_mask !== m_mask[e_sel] ||
          fe_wid !== 3'(e_sel)))) begin
        errors++;
        $display("FAIL rr_model: got v=%b pc=%h wid=%0d, want v=%b pc=%h wid=%0d",
                 fe_valid, fe_pc, fe_wid, e_fv, m_pc[e_sel], e_sel);
      end
      if (fe_valid) begin
        got_id[n] = int'(fe_wid); got_pc[n] = int'(fe_pc); n++;
      end
      if (e_fv) due[e_sel] = cyc + 2;
      upd_valid = 0;
      for (int w = 0; w < NW; w++) begin
        if (due[w] == cyc) begin
          upd_valid = 1; upd_id = 3'(w); upd_pc = m_pc[w] + 8'd1; upd_mask = 4'hF; upd_done = 0;
          due[w] = -1;
        end
      end
      tick();
    end
    upd_valid = 0; ic_ready = 0;
    checks++;
    if (n < 6) begin
      errors++;
      $display("FAIL rr_timeout: got %0d fetches, want 6", n);
    end
    for (int i = 0; i < n && i < 6; i++) begin
      checks++;
      if (got_id[i] != exp_id[i] || got_pc[i] != exp_pc[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got wid=%0d pc=%h, want wid=%0d pc=%h",
                 i, got_id[i], got_pc[i], exp_id[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int w = 0; w < 4; w++) begin
      alloc_valid = 1; alloc_pc = 8'h30 + 8'(w); alloc_mask = 4'hF;
      tick();
    end
    alloc_valid = 0;
    ic_ready = 1;
    repeat (3) tick();
    ic_ready = 0;
    for (int c = 0; c < 5; c++) begin
      alloc_valid = (c == 0); alloc_pc = 8'h77; alloc_mask = 4'h5;
      upd_valid = (c == 1); upd_id = 3'd0; upd_pc = 8'h55; upd_mask = 4'hF; upd_done = 0;
      checks++;
      if (fe_valid !== 1'b1 || fe_pc !== 8'h33 || fe_mask !== 4'hF || fe_wid !== 3'd3) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h mask=%h wid=%0d, want 1 33 f 3",
                 c, fe_valid, fe_pc, fe_mask, fe_wid);
      end
      tick();
    end
    alloc_valid = 0; upd_valid = 0;
    ic_ready = 1;
    tick();
    checks++;
    if (fe_valid !== 1'b1 || fe_wid !== 3'd4 || fe_pc !== 8'h77 || fe_mask !== 4'h5) begin
      errors++;
      $display("FAIL stall_next: got v=%b wid=%0d pc=%h mask=%h, want 1 4 77 5",
               fe_valid, fe_wid, fe_pc, fe_mask);
    end
    tick();
    checks++;
    if (fe_valid !== 1'b1 || fe_wid !== 3'd0 || fe_pc !== 8'h55) begin
      errors++;
      $display("FAIL stall_wrap: got v=%b wid=%0d pc=%h, want 1 0 55", fe_valid, fe_wid, fe_pc);
    end
    ic_ready = 0;
  endtask

  task automatic test_fill_free();
    int order [7] = '{0, 1, 2, 3, 4, 6, 7};
    do_reset();
    ic_ready = 1;
    for (int w = 0; w < NW; w++) begin
      alloc_valid = 1; alloc_pc = 8'h80 + 8'(w); alloc_mask = 4'hF;
      tick();
    end
    alloc_valid = 0;
    for (int i = 0; i < 10 && e_fv; i++) tick();
    checks++;
    if (alloc_ready !== 1'b0 || busy !== 1'b1 || fe_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got ar=%b busy=%b fv=%b, want 0 1 0", alloc_ready, busy, fe_valid);
    end
    upd_valid = 1; upd_id = 3'd5; upd_done = 1; upd_mask = 4'hF; upd_pc = 8'h00;
    tick();
    checks++;
    if (alloc_ready !== 1'b1 || alloc_id !== 3'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_free5: got ar=%b id=%0d busy=%b, want 1 5 1", alloc_ready, alloc_id, busy);
    end
    for (int i = 0; i < 7; i++) begin
      upd_id = 3'(order[i]);
      tick();
      checks++;
      if (busy !== ((i == 6) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL fill_busy[%0d]: got %b, want %b", i, busy, (i == 6) ? 1'b0 : 1'b1);
      end
    end
    upd_valid = 0; upd_done = 0; ic_ready = 0;
  endtask

  task automatic test_mask_zero();
    do_reset();
    alloc_valid = 1; alloc_pc = 8'h12; alloc_mask = 4'h3; ic_ready = 1;
    tick();
    alloc_valid = 0;
    tick();
    upd_valid = 1; upd_id = 3'd0; upd_pc = 8'h13; upd_mask = 4'h0; upd_done = 0;
    tick();
    upd_valid = 0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (fe_valid !== 1'b0 || busy !== 1'b0 || alloc_ready !== 1'b1 || alloc_id !== 3'd0) begin
        errors++;
        $display("FAIL mask_zero[%0d]: got fv=%b busy=%b ar=%b id=%0d, want 0 0 1 0",
                 c, fe_valid, busy, alloc_ready, alloc_id);
      end
      tick();
    end
    ic_ready = 0;
  endtask

  task automatic test_random();
    int q[$];
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++;
      if (fe_valid !== e_fv || (e_fv && (fe_pc !== m_pc[e_sel] || fe_mask !== m_mask[e_sel] ||
          fe_wid !== 3'(e_sel)))) begin
        errors++;
        $display("FAIL rand_fe[%0d]: got v=%b pc=%h mask=%h wid=%0d, want v=%b pc=%h mask=%h wid=%0d",
                 cyc, fe_valid, fe_pc, fe_mask, fe_wid, e_fv, m_pc[e_sel], m_mask[e_sel], e_sel);
      end
      checks++;
      if (alloc_ready !== e_ar || (e_ar && alloc_id !== 3'(e_aid)) || busy !== e_busy ||
          fetch_cnt !== CW'(exp_cnt())) begin
        errors++;
        $display("FAIL rand_ctl[%0d]: got ar=%b id=%0d busy=%b cnt=%0d, want ar=%b id=%0d busy=%b cnt=%0d",
                 cyc, alloc_ready, alloc_id, busy, fetch_cnt, e_ar, e_aid, e_busy, exp_cnt());
      end
      alloc_valid = ($urandom_range(0, 99) < 40);
      alloc_pc = 8'($urandom);
      alloc_mask = 4'($urandom_range(1, 15));
      ic_ready = ($urandom_range(0, 99) < 70);
      q.delete();
      for (int w = 0; w < NW; w++) if (m_st[w] == M_OUT) q.push_back(w);
      upd_valid = (q.size() > 0) && ($urandom_range(0, 99) < 50);
      upd_id = (q.size() > 0) ? 3'(q[$urandom_range(0, q.size() - 1)]) : 3'd0;
      upd_pc = 8'($urandom);
      upd_mask = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      upd_done = ($urandom_range(0, 9) == 0);
      tick();
    end
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if (fe_valid !== 1'b0 || busy !== 1'b0 || alloc_ready !== 1'b1 || alloc_id !== 3'd0 ||
        fetch_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset: got fv=%b busy=%b ar=%b id=%0d cnt=%0d, want 0 0 1 0 0",
               fe_valid, busy, alloc_ready, alloc_id, fetch_cnt);
    end
  endtask

  task automatic test_perf();
    int nf = 0;
    do_reset();
    alloc_valid = 1; alloc_pc = 8'h00; alloc_mask = 4'hF; ic_ready = 1;
    tick();
    alloc_valid = 0;
    for (int cyc = 0; cyc < 100 && nf < 20; cyc++) begin
      if (e_fv) nf++;
      upd_valid = (m_st[0] == M_OUT); upd_id = 3'd0; upd_pc = m_pc[0] + 8'd1;
      upd_mask = 4'hF; upd_done = 0;
      tick();
      checks++;
      if (fetch_cnt !== CW'(exp_cnt())) begin
        errors++;
        $display("FAIL perf_track[%0d]: got %0d, want %0d", cyc, fetch_cnt, exp_cnt());
      end
    end
    upd_valid = 0; ic_ready = 0;
    checks++;
`ifdef BGPU_WFS_PERF_EN
    if (nf != 20 || fetch_cnt !== 4'd15) begin
      errors++;
      $display("FAIL perf_sat: got cnt=%0d after %0d fetches, want 15 after 20", fetch_cnt, nf);
    end
`else
    if (nf != 20 || fetch_cnt !== 4'd0) begin
      errors++;
      $display("FAIL perf_off: got cnt=%0d after %0d fetches, want 0 after 20", fetch_cnt, nf);
    end
`endif
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_first_fetch();
    test_round_robin();
    test_stall();
    test_fill_free();
    test_mask_zero();
    test_random();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
